// File: rtl/digit_chain_pkg.sv
// Shared digit width, terminal values and per-digit helpers for the digit chain counter.
package digit_chain_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
    localparam logic [DIGIT_W-1:0] BIN_MAX = 4'd15;

    function automatic logic [DIGIT_W-1:0] digit_max(input logic is_bcd);
        return is_bcd ? BCD_MAX : BIN_MAX;
    endfunction

    function automatic logic digit_valid(input logic [DIGIT_W-1:0] value, input logic is_bcd);
        return !is_bcd || (value <= BCD_MAX);
    endfunction

endpackage

// File: rtl/digit_chain_counter_cell.sv
// One 4-bit counter digit, binary or BCD. With DIGIT_CHAIN_LOAD_CLAMP_EN defined,
// loaded BCD values above 9 are stored as 9.
module digit_cell
    import digit_chain_pkg::*;
#(
    parameter bit IS_BCD = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    input  logic               dec,
    input  logic               ld,
    input  logic [DIGIT_W-1:0] d,
    output logic [DIGIT_W-1:0] q,
    output logic               is_max,
    output logic               is_zero
);

    localparam logic [DIGIT_W-1:0] MAX = digit_max(IS_BCD);

    logic [DIGIT_W-1:0] r_q;
    logic [DIGIT_W-1:0] w_up;
    logic [DIGIT_W-1:0] w_dn;
    logic [DIGIT_W-1:0] w_load;
    logic               w_valid;

    // An out-of-range BCD value steps to 0 going up and to 9 going down.
    always_comb begin
        w_valid = digit_valid(r_q, IS_BCD);
        w_up    = (!w_valid || (r_q == MAX)) ? '0 : r_q + DIGIT_W'(1);
        w_dn    = !w_valid ? BCD_MAX : ((r_q == '0) ? MAX : r_q - DIGIT_W'(1));
`ifdef DIGIT_CHAIN_LOAD_CLAMP_EN
        w_load  = digit_valid(d, IS_BCD) ? d : BCD_MAX;
`else
        w_load  = d;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (ld) begin
            r_q <= w_load;
        end else if (inc) begin
            r_q <= w_up;
        end else if (dec) begin
            r_q <= w_dn;
        end
    end

    assign q       = r_q;
    assign is_max  = (r_q == MAX);
    assign is_zero = (r_q == '0);

endmodule

// File: rtl/digit_chain_counter.sv
// N-digit mixed binary/BCD up/down counter with load, wrap/saturate and terminal pulse.
// Optional macro DIGIT_CHAIN_LOAD_CLAMP_EN clamps loaded BCD digits to 9.
module digit_chain_counter
    import digit_chain_pkg::*;
#(
    parameter int unsigned     NDIG     = 4,
    parameter logic [NDIG-1:0] BCD_MASK = NDIG'(4'b1100),
    parameter bit              WRAP     = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    up,
    input  logic                    dw,
    input  logic                    ld,
    input  logic [DIGIT_W*NDIG-1:0] din,
    output logic [DIGIT_W*NDIG-1:0] q,
    output logic                    utc,
    output logic                    dtc,
    output logic                    evt
);

    logic [NDIG-1:0] w_is_max;
    logic [NDIG-1:0] w_is_zero;
    logic [NDIG-1:0] w_carry;
    logic [NDIG-1:0] w_borrow;
    logic [NDIG-1:0] w_inc;
    logic [NDIG-1:0] w_dec;
    logic            w_up_req;
    logic            w_dn_req;
    logic            w_utc;
    logic            w_dtc;
    logic            w_hit;
    logic            w_freeze;
    logic            r_evt;

    // Digit i steps only when every lower digit sits at its terminal value.
    always_comb begin
        w_carry     = '0;
        w_borrow    = '0;
        w_carry[0]  = 1'b1;
        w_borrow[0] = 1'b1;
        for (int i = 1; i < NDIG; i++) begin
            w_carry[i]  = w_carry[i-1] & w_is_max[i-1];
            w_borrow[i] = w_borrow[i-1] & w_is_zero[i-1];
        end
    end

    always_comb begin
        w_up_req = up & ~dw & ~ld;
        w_dn_req = dw & ~up & ~ld;
        w_utc    = &w_is_max;
        w_dtc    = &w_is_zero;
        w_hit    = (w_up_req & w_utc) | (w_dn_req & w_dtc);
        w_freeze = ~WRAP & w_hit;
        w_inc    = {NDIG{w_up_req & ~w_freeze}} & w_carry;
        w_dec    = {NDIG{w_dn_req & ~w_freeze}} & w_borrow;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_evt <= 1'b0;
        end else begin
            r_evt <= w_hit;
        end
    end

    for (genvar g = 0; g < NDIG; g++) begin : g_digit
        digit_cell #(
            .IS_BCD (BCD_MASK[g])
        ) u_digit (
            .clk     (clk),
            .rst     (rst),
            .inc     (w_inc[g]),
            .dec     (w_dec[g]),
            .ld      (ld),
            .d       (din[g*DIGIT_W +: DIGIT_W]),
            .q       (q[g*DIGIT_W +: DIGIT_W]),
            .is_max  (w_is_max[g]),
            .is_zero (w_is_zero[g])
        );
    end

    assign utc = w_utc;
    assign dtc = w_dtc;
    assign evt = r_evt;

endmodule

// File: tb/tb_digit_chain_counter.sv
// Self-checking bench: a wrapping and a saturating counter driven in lockstep, checked via a scoreboard.
module tb_digit_chain_counter;

    localparam logic [3:0] TB_BCD = 4'b1100;

`ifdef DIGIT_CHAIN_LOAD_CLAMP_EN
    localparam logic [15:0] Q_C000   = 16'h9000;
    localparam logic [15:0] Q_C001   = 16'h9001;
    localparam logic [15:0] Q_CDN    = 16'h89FF;
    localparam logic [15:0] Q_AFF    = 16'h09FF;
    localparam logic [15:0] Q_AFF_UP = 16'h1000;
    localparam logic [15:0] Q_LONG_S = 16'h99FF;
`else
    localparam logic [15:0] Q_C000   = 16'hC000;
    localparam logic [15:0] Q_C001   = 16'hC001;
    localparam logic [15:0] Q_CDN    = 16'h99FF;
    localparam logic [15:0] Q_AFF    = 16'h0AFF;
    localparam logic [15:0] Q_AFF_UP = 16'h0000;
    localparam logic [15:0] Q_LONG_S = 16'h0000;
`endif

    typedef struct {
        logic [15:0] q_w;
        logic        e_w;
        logic [15:0] q_s;
        logic        e_s;
    } exp_t;

    typedef struct {
        logic        ld;
        logic        up;
        logic        dw;
        logic [15:0] din;
        exp_t        e;
    } vec_t;

    logic        clk, rst, up, dw, ld;
    logic [15:0] din;
    logic [15:0] q_w, q_s;
    logic        utc_w, dtc_w, evt_w, utc_s, dtc_s, evt_s;

    int   n_pass = 0;
    int   n_tot  = 0;
    exp_t sb[$];

    digit_chain_counter #(.NDIG(4), .BCD_MASK(4'b1100), .WRAP(1'b1)) u_dut_wrap (
        .clk(clk), .rst(rst), .up(up), .dw(dw), .ld(ld), .din(din),
        .q(q_w), .utc(utc_w), .dtc(dtc_w), .evt(evt_w)
    );

    digit_chain_counter #(.NDIG(4), .BCD_MASK(4'b1100), .WRAP(1'b0)) u_dut_sat (
        .clk(clk), .rst(rst), .up(up), .dw(dw), .ld(ld), .din(din),
        .q(q_s), .utc(utc_s), .dtc(dtc_s), .evt(evt_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic exp_utc(input logic [15:0] v);
        logic [3:0] mx;
        for (int i = 0; i < 4; i++) begin
            mx = TB_BCD[i] ? 4'd9 : 4'd15;
            if (v[i*4 +: 4] != mx) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Reference: ripple the step through the digits one at a time.
    function automatic void model(input logic [15:0] cq, input logic l, input logic u, input logic d,
                                  input logic [15:0] di, input bit wrap,
                                  output logic [15:0] nq, output logic ne);
        logic [3:0] dg, mx;
        logic       cy;
        nq = cq;
        ne = 1'b0;
        if (l) begin
            for (int i = 0; i < 4; i++) begin
                dg = di[i*4 +: 4];
`ifdef DIGIT_CHAIN_LOAD_CLAMP_EN
                if (TB_BCD[i] && dg > 4'd9) dg = 4'd9;
`endif
                nq[i*4 +: 4] = dg;
            end
        end else if (u && !d) begin
            if (exp_utc(cq)) begin
                ne = 1'b1;
                nq = wrap ? 16'h0000 : cq;
            end else begin
                cy = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    if (cy) begin
                        dg = cq[i*4 +: 4];
                        mx = TB_BCD[i] ? 4'd9 : 4'd15;
                        if (dg == mx)     begin dg = 4'd0; cy = 1'b1; end
                        else if (dg > mx) begin dg = 4'd0; cy = 1'b0; end
                        else              begin dg = dg + 4'd1; cy = 1'b0; end
                        nq[i*4 +: 4] = dg;
                    end
                end
            end
        end else if (d && !u) begin
            if (cq == 16'h0000) begin
                ne = 1'b1;
                nq = wrap ? 16'h99FF : cq;
            end else begin
                cy = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    if (cy) begin
                        dg = cq[i*4 +: 4];
                        mx = TB_BCD[i] ? 4'd9 : 4'd15;
                        if (dg > mx)        begin dg = 4'd9; cy = 1'b0; end
                        else if (dg == 4'd0) begin dg = mx; cy = 1'b1; end
                        else                begin dg = dg - 4'd1; cy = 1'b0; end
                        nq[i*4 +: 4] = dg;
                    end
                end
            end
        end
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_tot++;
            $display("FAIL scoreboard_empty actual=0 required=1");
            return;
        end
        e = sb.pop_front();
        chk("q_wrap",   q_w,          e.q_w);
        chk("evt_wrap", 16'(evt_w),   16'(e.e_w));
        chk("utc_wrap", 16'(utc_w),   16'(exp_utc(e.q_w)));
        chk("dtc_wrap", 16'(dtc_w),   16'(e.q_w == 16'h0000));
        chk("q_sat",    q_s,          e.q_s);
        chk("evt_sat",  16'(evt_s),   16'(e.e_s));
        chk("utc_sat",  16'(utc_s),   16'(exp_utc(e.q_s)));
        chk("dtc_sat",  16'(dtc_s),   16'(e.q_s == 16'h0000));
    endtask

    task automatic apply(input logic l, input logic u, input logic d, input logic [15:0] di, input exp_t e);
        @(negedge clk);
        ld  = l;
        up  = u;
        dw  = d;
        din = di;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    vec_t        vec[22];
    logic [15:0] m_w, m_s, nw, ns;
    logic        ew, es;

    initial begin
        vec[0]  = '{1'b1, 1'b0, 1'b0, 16'h0999, '{16'h0999, 1'b0, 16'h0999, 1'b0}};
        vec[1]  = '{1'b0, 1'b1, 1'b0, 16'h0000, '{16'h099A, 1'b0, 16'h099A, 1'b0}};
        vec[2]  = '{1'b1, 1'b0, 1'b0, 16'h09FF, '{16'h09FF, 1'b0, 16'h09FF, 1'b0}};
        vec[3]  = '{1'b0, 1'b1, 1'b0, 16'h0000, '{16'h1000, 1'b0, 16'h1000, 1'b0}};
        vec[4]  = '{1'b1, 1'b0, 1'b0, 16'h99FF, '{16'h99FF, 1'b0, 16'h99FF, 1'b0}};
        vec[5]  = '{1'b0, 1'b1, 1'b0, 16'h0000, '{16'h0000, 1'b1, 16'h99FF, 1'b1}};
        vec[6]  = '{1'b0, 1'b0, 1'b0, 16'h0000, '{16'h0000, 1'b0, 16'h99FF, 1'b0}};
        vec[7]  = '{1'b0, 1'b0, 1'b1, 16'h0000, '{16'h99FF, 1'b1, 16'h99FE, 1'b0}};
        vec[8]  = '{1'b1, 1'b0, 1'b0, 16'h0000, '{16'h0000, 1'b0, 16'h0000, 1'b0}};
        vec[9]  = '{1'b0, 1'b0, 1'b1, 16'h0000, '{16'h99FF, 1'b1, 16'h0000, 1'b1}};
        vec[10] = '{1'b0, 1'b0, 1'b1, 16'h0000, '{16'h99FE, 1'b0, 16'h0000, 1'b1}};
        vec[11] = '{1'b1, 1'b1, 1'b1, 16'h1234, '{16'h1234, 1'b0, 16'h1234, 1'b0}};
        vec[12] = '{1'b0, 1'b1, 1'b1, 16'h0000, '{16'h1234, 1'b0, 16'h1234, 1'b0}};
        vec[13] = '{1'b0, 1'b0, 1'b1, 16'h0000, '{16'h1233, 1'b0, 16'h1233, 1'b0}};
        vec[14] = '{1'b1, 1'b0, 1'b0, 16'h0100, '{16'h0100, 1'b0, 16'h0100, 1'b0}};
        vec[15] = '{1'b0, 1'b0, 1'b1, 16'h0000, '{16'h00FF, 1'b0, 16'h00FF, 1'b0}};
        vec[16] = '{1'b1, 1'b0, 1'b0, 16'hC000, '{Q_C000,   1'b0, Q_C000,   1'b0}};
        vec[17] = '{1'b0, 1'b1, 1'b0, 16'h0000, '{Q_C001,   1'b0, Q_C001,   1'b0}};
        vec[18] = '{1'b1, 1'b0, 1'b0, 16'hC000, '{Q_C000,   1'b0, Q_C000,   1'b0}};
        vec[19] = '{1'b0, 1'b0, 1'b1, 16'h0000, '{Q_CDN,    1'b0, Q_CDN,    1'b0}};
        vec[20] = '{1'b1, 1'b0, 1'b0, 16'h0AFF, '{Q_AFF,    1'b0, Q_AFF,    1'b0}};
        vec[21] = '{1'b0, 1'b1, 1'b0, 16'h0000, '{Q_AFF_UP, 1'b0, Q_AFF_UP, 1'b0}};

        rst = 1'b1;
        ld  = 1'b0;
        up  = 1'b1;
        dw  = 1'b0;
        din = 16'h0000;

        // Reset holds the counters at zero even with a count request present.
        repeat (2) @(posedge clk);
        #1;
        sb.push_back('{16'h0000, 1'b0, 16'h0000, 1'b0});
        check_out();
        @(negedge clk);
        rst = 1'b0;
        up  = 1'b0;

        foreach (vec[i]) apply(vec[i].ld, vec[i].up, vec[i].dw, vec[i].din, vec[i].e);

        // Asynchronous reset mid-count from 0395.
        apply(1'b1, 1'b0, 1'b0, 16'h0395, '{16'h0395, 1'b0, 16'h0395, 1'b0});
        @(negedge clk);
        ld = 1'b0;
        up = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_q",   q_w,         16'h0000);
        chk("async_rst_dtc", 16'(dtc_w),  16'h0001);
        @(posedge clk);
        #1;
        sb.push_back('{16'h0000, 1'b0, 16'h0000, 1'b0});
        check_out();
        @(negedge clk);
        rst = 1'b0;
        up  = 1'b0;

        // Asynchronous reset clears a live evt pulse.
        apply(1'b1, 1'b0, 1'b0, 16'h99FF, '{16'h99FF, 1'b0, 16'h99FF, 1'b0});
        apply(1'b0, 1'b1, 1'b0, 16'h0000, '{16'h0000, 1'b1, 16'h99FF, 1'b1});
        up = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_evt_w", 16'(evt_w), 16'h0000);
        chk("async_rst_evt_s", 16'(evt_s), 16'h0000);
        chk("async_rst_q_s",   q_s,        16'h0000);
        @(negedge clk);
        rst = 1'b0;

        // Long up run through an out-of-range BCD top digit, tracked by the reference model.
        m_w = 16'h0000;
        m_s = 16'h0000;
        model(m_w, 1'b1, 1'b0, 1'b0, 16'hC000, 1'b1, nw, ew);
        model(m_s, 1'b1, 1'b0, 1'b0, 16'hC000, 1'b0, ns, es);
        m_w = nw;
        m_s = ns;
        apply(1'b1, 1'b0, 1'b0, 16'hC000, '{nw, ew, ns, es});
        for (int k = 0; k < 2560; k++) begin
            model(m_w, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, nw, ew);
            model(m_s, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, ns, es);
            m_w = nw;
            m_s = ns;
            apply(1'b0, 1'b1, 1'b0, 16'h0000, '{nw, ew, ns, es});
        end
        chk("long_final_w", q_w, 16'h0000);
        chk("long_final_s", q_s, Q_LONG_S);

        @(negedge clk);
        up = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
